// File: rtl/player_move_ctrl.sv
// Initiator side of the player-move handshake: turns keypresses into move requests
// and commits the interaction engine's answer into the authoritative player registers.
module player_move_ctrl #(
  parameter int MAP_WIDTH    = 11,
  parameter int MAP_HEIGHT   = 11,
  parameter int START_X      = 5,
  parameter int START_Y      = 10,
  parameter int START_HEALTH = 1000,
  parameter int TIMEOUT      = 15,
  parameter int COOLDOWN     = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        key_valid,
  input  logic [3:0]  key_dir,
  input  logic        accept_move,
  input  logic [15:0] floor_in,
  input  logic [3:0]  goto_x,
  input  logic [3:0]  goto_y,
  input  logic [3:0]  key_num_in,
  input  logic [15:0] health_in,
  output logic        player_ask_move,
  output logic [3:0]  player_ask_x,
  output logic [3:0]  player_ask_y,
  output logic [3:0]  player_x,
  output logic [3:0]  player_y,
  output logic [15:0] floor,
  output logic [3:0]  key_num,
  output logic [15:0] health,
  output logic [1:0]  facing,
  output logic        busy,
  output logic        dead
);

  localparam int CW = 8;
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] COOL_LAST    = CW'((COOLDOWN == 0) ? 0 : COOLDOWN - 1);
  localparam logic signed [4:0] MAP_W5   = 5'(MAP_WIDTH);
  localparam logic signed [4:0] MAP_H5   = 5'(MAP_HEIGHT);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, COOL, DEAD} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            buf_full;
  logic [1:0]      buf_dir;

  logic            key_ok;
  logic [1:0]      key_code;
  logic            sel_valid;
  logic [1:0]      sel_dir;
  logic signed [4:0] tx;
  logic signed [4:0] ty;
  logic            in_range;

  always_comb begin
    key_code = 2'd0;
    case (key_dir)
      4'b1000: key_code = 2'd0;
      4'b0100: key_code = 2'd1;
      4'b0010: key_code = 2'd2;
      4'b0001: key_code = 2'd3;
      default: key_code = 2'd0;
    endcase
    key_ok = key_valid && $onehot(key_dir);
  end

  // A buffered key always takes priority over a live one in IDLE.
  always_comb begin
    sel_valid = buf_full || key_ok;
    sel_dir   = buf_full ? buf_dir : key_code;
    tx        = $signed({1'b0, player_x});
    ty        = $signed({1'b0, player_y});
    case (sel_dir)
      2'd0:    ty = ty - 5'sd1;
      2'd1:    ty = ty + 5'sd1;
      2'd2:    tx = tx - 5'sd1;
      default: tx = tx + 5'sd1;
    endcase
    in_range = (tx >= 5'sd0) && (tx < MAP_W5) && (ty >= 5'sd0) && (ty < MAP_H5);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= IDLE;
      cnt             <= '0;
      buf_full        <= 1'b0;
      buf_dir         <= 2'd0;
      player_x        <= 4'(START_X);
      player_y        <= 4'(START_Y);
      floor           <= 16'd0;
      key_num         <= 4'd0;
      health          <= 16'(START_HEALTH);
      facing          <= 2'd0;
      player_ask_move <= 1'b0;
      player_ask_x    <= 4'(START_X);
      player_ask_y    <= 4'(START_Y);
      busy            <= 1'b0;
      dead            <= 1'b0;
    end else begin
      player_ask_move <= 1'b0;
      if (key_ok && state != DEAD) begin
        facing <= key_code;
      end
      if (key_ok && state != DEAD && state != IDLE) begin
        buf_full <= 1'b1;
        buf_dir  <= key_code;
      end
      case (state)
        IDLE: begin
          if (buf_full) begin
            buf_full <= key_ok;
            if (key_ok) begin
              buf_dir <= key_code;
            end
          end
          if (sel_valid && in_range) begin
            player_ask_x    <= tx[3:0];
            player_ask_y    <= ty[3:0];
            player_ask_move <= 1'b1;
            busy            <= 1'b1;
            state           <= REQ;
          end
        end
        REQ: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // Accept wins over a timeout landing on the same edge.
          if (accept_move) begin
            player_x <= goto_x;
            player_y <= goto_y;
            floor    <= floor_in;
            key_num  <= key_num_in;
            health   <= health_in;
            cnt      <= '0;
            if (health_in == 16'd0) begin
              state    <= DEAD;
              dead     <= 1'b1;
              buf_full <= 1'b0;
            end else begin
              state <= COOL;
            end
          end else if (cnt == TIMEOUT_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        COOL: begin
          if (cnt == COOL_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DEAD: begin
          buf_full <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_player_move_ctrl.sv
// Directed testbench for player_move_ctrl; each task drives one scenario and
// checks hand-computed expectations at the falling edge.
module tb_player_move_ctrl;

  logic        clk;
  logic        rstn;
  logic        key_valid;
  logic [3:0]  key_dir;
  logic        accept_move;
  logic [15:0] floor_in;
  logic [3:0]  goto_x;
  logic [3:0]  goto_y;
  logic [3:0]  key_num_in;
  logic [15:0] health_in;
  logic        player_ask_move;
  logic [3:0]  player_ask_x;
  logic [3:0]  player_ask_y;
  logic [3:0]  player_x;
  logic [3:0]  player_y;
  logic [15:0] floor;
  logic [3:0]  key_num;
  logic [15:0] health;
  logic [1:0]  facing;
  logic        busy;
  logic        dead;

  int checks = 0;
  int failures = 0;
  int ask_count = 0;
  int c0;
  logic [3:0] last_ask_x;
  logic [3:0] last_ask_y;

  player_move_ctrl dut (
    .clk(clk), .rstn(rstn), .key_valid(key_valid), .key_dir(key_dir),
    .accept_move(accept_move), .floor_in(floor_in), .goto_x(goto_x), .goto_y(goto_y),
    .key_num_in(key_num_in), .health_in(health_in), .player_ask_move(player_ask_move),
    .player_ask_x(player_ask_x), .player_ask_y(player_ask_y), .player_x(player_x),
    .player_y(player_y), .floor(floor), .key_num(key_num), .health(health),
    .facing(facing), .busy(busy), .dead(dead)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Independent request monitor: counts pulses and remembers the last target.
  always @(posedge clk) begin
    if (player_ask_move === 1'b1) begin
      ask_count++;
      last_ask_x <= player_ask_x;
      last_ask_y <= player_ask_y;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [3:0] dir);
    key_valid = 1'b1;
    key_dir   = dir;
    @(negedge clk);
    key_valid = 1'b0;
    key_dir   = 4'd0;
  endtask

  task automatic accept(input logic [3:0] gx, input logic [3:0] gy, input logic [15:0] hp,
                        input logic [15:0] fl, input logic [3:0] kn);
    accept_move = 1'b1;
    goto_x = gx; goto_y = gy; health_in = hp; floor_in = fl; key_num_in = kn;
    @(negedge clk);
    accept_move = 1'b0;
  endtask

  task automatic test_reset;
    tick(2);
    checks++; if (player_x !== 4'd5) begin failures++; $display("[TB] FAIL reset_x got=%0d exp=5", player_x); end
    checks++; if (player_y !== 4'd10) begin failures++; $display("[TB] FAIL reset_y got=%0d exp=10", player_y); end
    checks++; if (health !== 16'd1000) begin failures++; $display("[TB] FAIL reset_health got=%0d exp=1000", health); end
    checks++; if ({floor, key_num, facing} !== 22'd0) begin failures++; $display("[TB] FAIL reset_floor_keys_facing got=%0h exp=0", {floor, key_num, facing}); end
    checks++; if ({player_ask_move, busy, dead} !== 3'b000) begin failures++; $display("[TB] FAIL reset_flags got=%b exp=000", {player_ask_move, busy, dead}); end
    checks++; if ({player_ask_x, player_ask_y} !== {4'd5, 4'd10}) begin failures++; $display("[TB] FAIL reset_ask_xy got=%0d,%0d exp=5,10", player_ask_x, player_ask_y); end
    rstn = 1'b1;
    tick(1);
  endtask

  task automatic test_invalid_key;
    c0 = ask_count;
    press(4'b0011);
    checks++; if ({player_ask_move, busy, facing} !== 4'b0000) begin failures++; $display("[TB] FAIL invalid_key got=%b exp=0000", {player_ask_move, busy, facing}); end
    press(4'b0000);
    // Down from y=10 lands on y=11, outside the map: rejected, facing still updates.
    press(4'b0100);
    checks++; if (facing !== 2'd1) begin failures++; $display("[TB] FAIL bottom_edge_facing got=%0d exp=1", facing); end
    checks++; if ({player_ask_move, busy} !== 2'b00) begin failures++; $display("[TB] FAIL bottom_edge_reject got=%b exp=00", {player_ask_move, busy}); end
    tick(2);
    checks++; if (ask_count !== c0) begin failures++; $display("[TB] FAIL invalid_no_ask got=%0d exp=%0d", ask_count, c0); end
  endtask

  task automatic test_move_right;
    press(4'b0001);
    checks++; if (player_ask_move !== 1'b1) begin failures++; $display("[TB] FAIL right_ask_pulse got=%b exp=1", player_ask_move); end
    checks++; if ({player_ask_x, player_ask_y} !== {4'd6, 4'd10}) begin failures++; $display("[TB] FAIL right_ask_xy got=%0d,%0d exp=6,10", player_ask_x, player_ask_y); end
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL right_busy got=%b exp=1", busy); end
    tick(1);
    checks++; if (player_ask_move !== 1'b0) begin failures++; $display("[TB] FAIL right_pulse_width got=%b exp=0", player_ask_move); end
    tick(2);
    accept(4'd6, 4'd10, 16'd990, 16'd1, 4'd2);
    checks++; if ({player_x, player_y} !== {4'd6, 4'd10}) begin failures++; $display("[TB] FAIL right_commit_xy got=%0d,%0d exp=6,10", player_x, player_y); end
    checks++; if ({health, floor, key_num} !== {16'd990, 16'd1, 4'd2}) begin failures++; $display("[TB] FAIL right_commit_regs got=%0d,%0d,%0d exp=990,1,2", health, floor, key_num); end
    checks++; if (facing !== 2'd3) begin failures++; $display("[TB] FAIL right_facing got=%0d exp=3", facing); end
    tick(3);
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL cool_last_cycle_busy got=%b exp=1", busy); end
    tick(1);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL cool_done_busy got=%b exp=0", busy); end
  endtask

  task automatic move_to_corner;
    press(4'b0010);
    tick(1);
    accept(4'd0, 4'd3, 16'd990, 16'd1, 4'd2);
    tick(5);
  endtask

  task automatic test_reject_offmap;
    c0 = ask_count;
    press(4'b0010);
    checks++; if ({player_ask_move, busy} !== 2'b00) begin failures++; $display("[TB] FAIL left_edge_reject got=%b exp=00", {player_ask_move, busy}); end
    checks++; if (facing !== 2'd2) begin failures++; $display("[TB] FAIL left_edge_facing got=%0d exp=2", facing); end
    tick(2);
    checks++; if (ask_count !== c0) begin failures++; $display("[TB] FAIL left_edge_no_ask got=%0d exp=%0d", ask_count, c0); end
  endtask

  task automatic test_timeout;
    c0 = ask_count;
    press(4'b1000);
    checks++; if ({player_ask_move, player_ask_x, player_ask_y} !== {1'b1, 4'd0, 4'd2}) begin failures++; $display("[TB] FAIL up_ask got=%b,%0d,%0d exp=1,0,2", player_ask_move, player_ask_x, player_ask_y); end
    tick(15);
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL timeout_last_wait_busy got=%b exp=1", busy); end
    tick(1);
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL timeout_idle got=%b exp=0", busy); end
    checks++; if ({player_x, player_y} !== {4'd0, 4'd3}) begin failures++; $display("[TB] FAIL timeout_pos got=%0d,%0d exp=0,3", player_x, player_y); end
    tick(1);
    accept(4'd9, 4'd9, 16'd500, 16'd7, 4'd7);
    checks++; if ({player_x, health, busy} !== {4'd0, 16'd990, 1'b0}) begin failures++; $display("[TB] FAIL late_accept got=%0d,%0d,%b exp=0,990,0", player_x, health, busy); end
    checks++; if (ask_count !== c0 + 1) begin failures++; $display("[TB] FAIL timeout_ask_count got=%0d exp=%0d", ask_count, c0 + 1); end
  endtask

  task automatic test_last_wins;
    int c1;
    press(4'b0001);
    press(4'b0100);
    press(4'b0001);
    c1 = ask_count;
    accept(4'd1, 4'd3, 16'd990, 16'd1, 4'd2);
    tick(5);
    checks++; if ({player_ask_move, player_ask_x, player_ask_y} !== {1'b1, 4'd2, 4'd3}) begin failures++; $display("[TB] FAIL buffered_ask got=%b,%0d,%0d exp=1,2,3", player_ask_move, player_ask_x, player_ask_y); end
    checks++; if (facing !== 2'd3) begin failures++; $display("[TB] FAIL buffered_facing got=%0d exp=3", facing); end
    tick(1);
    accept(4'd2, 4'd3, 16'd990, 16'd1, 4'd2);
    tick(10);
    checks++; if (ask_count !== c1 + 1) begin failures++; $display("[TB] FAIL last_wins_count got=%0d exp=%0d", ask_count, c1 + 1); end
    checks++; if ({last_ask_x, last_ask_y} !== {4'd2, 4'd3}) begin failures++; $display("[TB] FAIL last_wins_target got=%0d,%0d exp=2,3", last_ask_x, last_ask_y); end
    checks++; if ({player_x, busy} !== {4'd2, 1'b0}) begin failures++; $display("[TB] FAIL last_wins_commit got=%0d,%b exp=2,0", player_x, busy); end
  endtask

  task automatic test_dead;
    press(4'b0100);
    tick(1);
    accept(4'd2, 4'd4, 16'd0, 16'd1, 4'd2);
    checks++; if ({dead, busy, health} !== {1'b1, 1'b1, 16'd0}) begin failures++; $display("[TB] FAIL dead_entry got=%b,%b,%0d exp=1,1,0", dead, busy, health); end
    checks++; if (player_y !== 4'd4) begin failures++; $display("[TB] FAIL dead_commit_y got=%0d exp=4", player_y); end
    c0 = ask_count;
    press(4'b1000);
    press(4'b0001);
    tick(5);
    checks++; if (ask_count !== c0) begin failures++; $display("[TB] FAIL dead_no_ask got=%0d exp=%0d", ask_count, c0); end
    checks++; if ({dead, facing} !== {1'b1, 2'd1}) begin failures++; $display("[TB] FAIL dead_locked got=%b,%0d exp=1,1", dead, facing); end
  endtask

  task automatic test_reset_mid_wait;
    rstn = 1'b0;
    tick(1);
    rstn = 1'b1;
    tick(1);
    checks++; if (dead !== 1'b0) begin failures++; $display("[TB] FAIL reset_clears_dead got=%b exp=0", dead); end
    press(4'b1000);
    checks++; if ({player_ask_move, player_ask_x, player_ask_y} !== {1'b1, 4'd5, 4'd9}) begin failures++; $display("[TB] FAIL pre_reset_ask got=%b,%0d,%0d exp=1,5,9", player_ask_move, player_ask_x, player_ask_y); end
    tick(1);
    rstn = 1'b0;
    #1;
    checks++; if ({player_ask_x, player_ask_y, busy, player_ask_move} !== {4'd5, 4'd10, 1'b0, 1'b0}) begin failures++; $display("[TB] FAIL async_reset got=%0d,%0d,%b,%b exp=5,10,0,0", player_ask_x, player_ask_y, busy, player_ask_move); end
    checks++; if ({player_y, health, facing} !== {4'd10, 16'd1000, 2'd0}) begin failures++; $display("[TB] FAIL async_reset_regs got=%0d,%0d,%0d exp=10,1000,0", player_y, health, facing); end
    @(negedge clk);
    rstn = 1'b1;
    tick(2);
    accept(4'd7, 4'd7, 16'd5, 16'd3, 4'd3);
    checks++; if ({player_x, player_y, health, busy} !== {4'd5, 4'd10, 16'd1000, 1'b0}) begin failures++; $display("[TB] FAIL post_reset_accept got=%0d,%0d,%0d,%b exp=5,10,1000,0", player_x, player_y, health, busy); end
  endtask

  initial begin
    rstn = 1'b0;
    key_valid = 1'b0;
    key_dir = 4'd0;
    accept_move = 1'b0;
    floor_in = 16'd0;
    goto_x = 4'd0;
    goto_y = 4'd0;
    key_num_in = 4'd0;
    health_in = 16'd0;
    test_reset;
    test_invalid_key;
    test_move_right;
    move_to_corner;
    test_reject_offmap;
    test_timeout;
    test_last_wins;
    test_dead;
    test_reset_mid_wait;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
